// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. ALU results pass straight to write-back.
// Loads and stores perform one request/grant/response access on the data-memory port.
`default_nettype none

module mem_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  input  logic [63:0] res_i,
  input  logic [63:0] store_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        write_back_i,
  input  logic        load_flag_i,
  input  logic        mem_en_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_wstrb_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [63:0] wb_data_o,
  output logic        misalign_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state;
  logic [63:0] addr_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        wb_q;
  logic        ld_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;

  logic        accept;
  logic        misaligned;
  logic [2:0]  in_lane;
  logic [63:0] wdata_n;
  logic [7:0]  wstrb_n;
  logic [63:0] load_shifted;
  logic [63:0] load_ext;

  assign accept  = in_valid && (state == IDLE);
  assign in_lane = res_i[2:0];

  assign stall_o      = (state != IDLE);
  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = (state == REQ) && !ld_q;
  assign dmem_addr_o  = {addr_q[63:3], 3'b000};
  assign dmem_wdata_o = wdata_q;
  assign dmem_wstrb_o = wstrb_q;

  always_comb begin
    misaligned = 1'b0;
    wdata_n    = store_data_i;
    wstrb_n    = 8'hFF;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_n = {8{store_data_i[7:0]}};
        wstrb_n = 8'h01 << in_lane;
      end
      2'b01: begin
        misaligned = in_lane[0];
        wdata_n    = {4{store_data_i[15:0]}};
        wstrb_n    = 8'h03 << in_lane;
      end
      2'b10: begin
        misaligned = (in_lane[1:0] != 2'b00);
        wdata_n    = {2{store_data_i[31:0]}};
        wstrb_n    = 8'h0F << in_lane;
      end
      default: begin
        misaligned = (in_lane != 3'b000);
      end
    endcase
  end

  // Extract the addressed field from the aligned doubleword and extend it.
  always_comb begin
    load_shifted = dmem_rdata_i >> {addr_q[2:0], 3'b000};
    case (f3_q[1:0])
      2'b00:   load_ext = f3_q[2] ? {56'd0, load_shifted[7:0]}
                                  : {{56{load_shifted[7]}}, load_shifted[7:0]};
      2'b01:   load_ext = f3_q[2] ? {48'd0, load_shifted[15:0]}
                                  : {{48{load_shifted[15]}}, load_shifted[15:0]};
      2'b10:   load_ext = f3_q[2] ? {32'd0, load_shifted[31:0]}
                                  : {{32{load_shifted[31]}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= IDLE;
      addr_q     <= 64'd0;
      f3_q       <= 3'd0;
      rd_q       <= 5'd0;
      wb_q       <= 1'b0;
      ld_q       <= 1'b0;
      wdata_q    <= 64'd0;
      wstrb_q    <= 8'd0;
      wb_en_o    <= 1'b0;
      wb_rd_o    <= 5'd0;
      wb_data_o  <= 64'd0;
      misalign_o <= 1'b0;
    end else begin
      wb_en_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= res_i;
            f3_q    <= funct3_i;
            rd_q    <= rd_i;
            wb_q    <= write_back_i;
            ld_q    <= load_flag_i;
            wdata_q <= wdata_n;
            wstrb_q <= wstrb_n;
            if (!mem_en_i) begin
              wb_en_o   <= write_back_i;
              wb_data_o <= res_i;
              wb_rd_o   <= rd_i;
            end else if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) state <= ld_q ? WAIT : IDLE;
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            wb_en_o   <= wb_q;
            wb_data_o <= load_ext;
            wb_rd_o   <= rd_q;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a scoreboard of expected write-back
// and misalign pulses, checked by an independent monitor.
`default_nettype none

module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] res_i = '0;
  logic [63:0] store_data_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        write_back_i = 1'b0;
  logic        load_flag_i = 1'b0;
  logic        mem_en_i = 1'b0;
  logic [4:0]  rd_i = '0;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [63:0] dmem_rdata_i = '0;
  logic        wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;
  logic        misalign_o;

  mem_stage dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .res_i(res_i),
    .store_data_i(store_data_i), .funct3_i(funct3_i), .write_back_i(write_back_i),
    .load_flag_i(load_flag_i), .mem_en_i(mem_en_i), .rd_i(rd_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_en_o(wb_en_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   exp_misalign = 0;
  int   checks = 0;
  int   failures = 0;

  // Memory responder settings
  int          gnt_delay = 0;
  int          rv_delay = 0;
  logic [63:0] rd_word = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Memory responder: acts right after each rising edge on the current state.
  initial begin
    int  gcnt = 0;
    int  rcnt = 0;
    bit  rv_pending = 0;
    forever begin
      @(posedge CLK);
      #1;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (rv_pending) begin
        if (rcnt == rv_delay) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i  = rd_word;
          rv_pending    = 0;
        end else begin
          rcnt++;
        end
      end else if (dmem_req_o) begin
        if (gcnt == gnt_delay) begin
          dmem_gnt_i = 1'b1;
          gcnt       = 0;
          if (!dmem_we_o) begin
            rv_pending = 1;
            rcnt       = 0;
          end
        end else begin
          gcnt++;
        end
      end
    end
  end

  // Monitor: compare every write-back and misalign pulse against the scoreboard.
  always @(negedge CLK) begin
    if (wb_en_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb_en", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {59'd0, wb_rd_o}, {59'd0, e.rd});
        chk("wb_data", wb_data_o, e.data);
      end
    end
    if (misalign_o) begin
      if (exp_misalign == 0) chk("unexpected_misalign", 64'd1, 64'd0);
      else begin
        checks++;
        exp_misalign--;
      end
    end
  end

  // Present an item (held while stalled) and return #1 after the accepting edge.
  task automatic issue(input logic [63:0] res, input logic [63:0] sd, input logic [2:0] f3,
                       input logic wb, input logic ld, input logic men, input logic [4:0] rd);
    bit was_stall;
    int n = 0;
    in_valid = 1'b1; res_i = res; store_data_i = sd; funct3_i = f3;
    write_back_i = wb; load_flag_i = ld; mem_en_i = men; rd_i = rd;
    forever begin
      was_stall = stall_o;
      @(posedge CLK);
      #1;
      if (!was_stall) break;
      n++;
      if (n > 200) begin
        chk("issue_timeout", 64'd1, 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (stall_o && n < 200) begin
      n++;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int n;
    exp_t e;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_req", {63'd0, dmem_req_o}, 64'd0);
    chk("rst_we", {63'd0, dmem_we_o}, 64'd0);
    chk("rst_addr", dmem_addr_o, 64'd0);
    chk("rst_wdata", dmem_wdata_o, 64'd0);
    chk("rst_wstrb", {56'd0, dmem_wstrb_o}, 64'd0);
    chk("rst_wb_en", {63'd0, wb_en_o}, 64'd0);
    chk("rst_wb_rd", {59'd0, wb_rd_o}, 64'd0);
    chk("rst_wb_data", wb_data_o, 64'd0);
    chk("rst_misalign", {63'd0, misalign_o}, 64'd0);
    RST_N = 1'b1;
    idle_cycles(1);

    // ALU pass-through
    e.rd = 5'd5; e.data = 64'h1234; exp_q.push_back(e);
    issue(64'h1234, 64'd0, 3'b011, 1'b1, 1'b0, 1'b0, 5'd5);
    chk("alu_wb_en_t1", {63'd0, wb_en_o}, 64'd1);
    chk("alu_no_req", {63'd0, dmem_req_o}, 64'd0);
    chk("alu_no_stall", {63'd0, stall_o}, 64'd0);
    idle_cycles(1);

    // LB sign-extended, immediate gnt/rvalid
    rd_word = 64'h0000_0000_8000_0000; gnt_delay = 0; rv_delay = 0;
    e.rd = 5'd7; e.data = 64'hFFFF_FFFF_FFFF_FF80; exp_q.push_back(e);
    issue(64'h1003, 64'd0, 3'b000, 1'b1, 1'b1, 1'b1, 5'd7);
    chk("lb_req", {63'd0, dmem_req_o}, 64'd1);
    chk("lb_we", {63'd0, dmem_we_o}, 64'd0);
    chk("lb_addr", dmem_addr_o, 64'h1000);
    count_stall(n);
    chk("lb_stall_cycles", n, 64'd2);
    chk("lb_wb_en_t3", {63'd0, wb_en_o}, 64'd1);

    // LBU same address
    e.rd = 5'd8; e.data = 64'h80; exp_q.push_back(e);
    issue(64'h1003, 64'd0, 3'b100, 1'b1, 1'b1, 1'b1, 5'd8);
    count_stall(n);

    // LHU lane 2, LW sign lane 4
    rd_word = 64'h0000_0000_F00D_0000;
    e.rd = 5'd9; e.data = 64'hF00D; exp_q.push_back(e);
    issue(64'h3002, 64'd0, 3'b101, 1'b1, 1'b1, 1'b1, 5'd9);
    count_stall(n);
    rd_word = 64'h8765_4321_0000_0000;
    e.rd = 5'd10; e.data = 64'hFFFF_FFFF_8765_4321; exp_q.push_back(e);
    issue(64'h3004, 64'd0, 3'b010, 1'b1, 1'b1, 1'b1, 5'd10);
    count_stall(n);

    // SH with grant delayed 3 cycles
    gnt_delay = 3;
    issue(64'h2006, 64'hABCD, 3'b001, 1'b0, 1'b0, 1'b1, 5'd0);
    chk("sh_addr", dmem_addr_o, 64'h2000);
    chk("sh_wstrb", {56'd0, dmem_wstrb_o}, 64'hC0);
    chk("sh_wdata", dmem_wdata_o, 64'hABCD_ABCD_ABCD_ABCD);
    chk("sh_we", {63'd0, dmem_we_o}, 64'd1);
    n = 0;
    while (stall_o && n < 200) begin
      chk("sh_req_held", {63'd0, dmem_req_o}, 64'd1);
      chk("sh_addr_held", dmem_addr_o, 64'h2000);
      n++;
      @(posedge CLK);
      #1;
    end
    chk("sh_stall_cycles", n, 64'd4);
    chk("sh_req_low_after", {63'd0, dmem_req_o}, 64'd0);
    gnt_delay = 0;

    // SB lane 5 and SD
    issue(64'h2005, 64'h5A, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0);
    chk("sb_wstrb", {56'd0, dmem_wstrb_o}, 64'h20);
    chk("sb_wdata", dmem_wdata_o, 64'h5A5A_5A5A_5A5A_5A5A);
    count_stall(n);
    chk("sb_stall_cycles", n, 64'd1);
    issue(64'h2008, 64'h1122_3344_5566_7788, 3'b111, 1'b0, 1'b0, 1'b1, 5'd0);
    chk("sd_addr", dmem_addr_o, 64'h2008);
    chk("sd_wstrb", {56'd0, dmem_wstrb_o}, 64'hFF);
    chk("sd_wdata", dmem_wdata_o, 64'h1122_3344_5566_7788);
    count_stall(n);

    // Misaligned LW
    exp_misalign++;
    issue(64'h1002, 64'd0, 3'b010, 1'b1, 1'b1, 1'b1, 5'd11);
    chk("mis_pulse", {63'd0, misalign_o}, 64'd1);
    chk("mis_no_req", {63'd0, dmem_req_o}, 64'd0);
    chk("mis_no_wb", {63'd0, wb_en_o}, 64'd0);
    chk("mis_no_stall", {63'd0, stall_o}, 64'd0);
    idle_cycles(1);

    // LD with delayed rvalid, ALU op held upstream meanwhile
    rd_word = 64'h8123_4567_89AB_CDEF; rv_delay = 5;
    e.rd = 5'd12; e.data = 64'h8123_4567_89AB_CDEF; exp_q.push_back(e);
    issue(64'h4000, 64'd0, 3'b111, 1'b1, 1'b1, 1'b1, 5'd12);
    e.rd = 5'd13; e.data = 64'hBEEF; exp_q.push_back(e);
    issue(64'hBEEF, 64'd0, 3'b000, 1'b1, 1'b0, 1'b0, 5'd13);
    chk("held_alu_wb_en", {63'd0, wb_en_o}, 64'd1);
    idle_cycles(2);

    // Reset during WAIT; late rvalid must be ignored
    rv_delay = 1; rd_word = 64'hDEAD;
    issue(64'h5000, 64'd0, 3'b011, 1'b1, 1'b1, 1'b1, 5'd14);
    idle_cycles(1);
    chk("pre_rst_in_wait", {63'd0, stall_o}, 64'd1);
    RST_N = 1'b0;
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    chk("rst2_rvalid_seen", {63'd0, dmem_rvalid_i}, 64'd1);
    chk("rst2_stall", {63'd0, stall_o}, 64'd0);
    chk("rst2_req", {63'd0, dmem_req_o}, 64'd0);
    chk("rst2_wb_data", wb_data_o, 64'd0);
    chk("rst2_wb_rd", {59'd0, wb_rd_o}, 64'd0);
    chk("rst2_addr", dmem_addr_o, 64'd0);
    idle_cycles(4);

    chk("scoreboard_empty", exp_q.size(), 64'd0);
    chk("misalign_all_seen", exp_misalign, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly downstream of the ALU stage: it consumes the ALU result (address or data), the write-back, load and memory-enable flags and the destination register, then either passes ALU results through to write-back or performs one load/store on the data-memory port with a request/grant/response handshake. Loads are sign/zero-extended by size. The stage stalls the upstream pipeline while a memory access is outstanding.

## Interface
Parameters: none.

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream item present this cycle
- res_i  in  64  ALU result: write-back data, or byte address when mem_en_i=1
- store_data_i  in  64  rs2 value for stores
- funct3_i  in  3  [1:0] size (00 B, 01 H, 10 W, 11 D); [2] unsigned load
- write_back_i  in  1  instruction writes rd
- load_flag_i  in  1  1 = load, 0 = store (valid only when mem_en_i=1)
- mem_en_i  in  1  instruction accesses memory
- rd_i  in  5  destination register
- stall_o  out  1  upstream must hold its outputs; inputs ignored while high
- dmem_req_o  out  1  memory request valid
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  64  {res[63:3], 3'b000}
- dmem_wdata_o  out  64  replicated store data
- dmem_wstrb_o  out  8  byte enables
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  64  read data (aligned doubleword)
- wb_en_o  out  1  one-cycle write-back pulse
- wb_rd_o  out  5  write-back register
- wb_data_o  out  64  write-back data
- misalign_o  out  1  one-cycle misaligned-access pulse

## Operation
- Accept = in_valid && !stall_o. On accept, latch res_i, store_data_i, funct3_i, rd_i, write_back_i, load_flag_i.
- States IDLE, REQ, WAIT. stall_o = (state != IDLE), decoded from registered state only.
- IDLE, accept, mem_en_i=0: wb_en_o <= write_back_i, wb_data_o <= res_i, wb_rd_o <= rd_i; stay IDLE.
- IDLE, accept, mem_en_i=1, misaligned (H: addr[0]≠0; W: addr[1:0]≠0; D: addr[2:0]≠0): misalign_o <= 1, wb_en_o <= 0, no request; stay IDLE.
- IDLE, accept, aligned mem op: -> REQ.
- REQ: dmem_req_o=1, we/addr/wdata/wstrb stable until gnt. Store + gnt -> IDLE (no write-back). Load + gnt -> WAIT.
- WAIT: on dmem_rvalid_i: wb_data_o <= extended load, wb_en_o <= latched write_back, wb_rd_o <= latched rd; -> IDLE.
- lane = addr[2:0]. wstrb: B 8'h01<<lane, H 8'h03<<lane, W 8'h0F<<lane, D 8'hFF. wdata: B data[7:0] x8, H data[15:0] x4, W data[31:0] x2, D data. funct3_i[2] ignored for stores.
- Load: field = rdata >> (lane*8), truncated to size; funct3[2]=0 sign-extend, 1 zero-extend; size D ignores funct3[2].
- wb_en_o, misalign_o are single-cycle pulses; wb_data_o/wb_rd_o hold last value otherwise.
- dmem_rvalid_i outside WAIT and dmem_gnt_i outside REQ are ignored.

## Timing
- Reset (RST_N=0 at edge): state IDLE; stall_o, dmem_req_o, dmem_we_o, wb_en_o, misalign_o = 0; dmem_addr_o, dmem_wdata_o, wb_data_o = 0; dmem_wstrb_o = 0; wb_rd_o = 0. Reset mid-access abandons it; dmem_req_o low the cycle after; late rvalid ignored.
- Pass-through: accept at T -> wb_en_o at T+1.
- Load, accept T, gnt at T+1, rvalid at T+2: wb_en_o at T+3; stall_o high T+1..T+2.
- Store, accept T, gnt at T+1: stall_o high T+1 only; back in IDLE T+2.
- Each cycle without gnt in REQ or without rvalid in WAIT adds one stall cycle. rvalid never arrives in the gnt cycle.
- Upstream item presented while stall_o high is accepted the first cycle stall_o is low.

## Test plan
- ALU op res_i=0x1234, rd=5, write_back=1 -> T+1: wb_en_o=1, wb_rd_o=5, wb_data_o=0x1234, no dmem_req_o.
- LB addr 0x1003, rdata 0x0000_0000_8000_0000 (byte3=0x80), gnt/rvalid immediate -> wb_data_o=0xFFFF_FFFF_FFFF_FF80 at T+3; LBU same -> 0x80.
- SH addr 0x2006 data 0xABCD -> dmem_addr_o=0x2000, wstrb=8'hC0, wdata=0xABCD_ABCD_ABCD_ABCD, we=1; gnt delayed 3 cycles -> req held, stall_o high 4 cycles.
- LW addr 0x1002 -> misalign_o pulse at T+1, no request, wb_en_o=0, stall_o stays 0.
- LD with rvalid delayed 5 cycles, second ALU op held upstream -> load writes back first, ALU op one cycle after stall_o drops.
- RST_N low during WAIT, rvalid arrives next cycle -> all outputs reset values, no wb_en_o pulse.
